serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It sequences a single `full_adder` instance over W cycles to add two W-bit operands, LSB first.
- The carry is held in a flip-flop between bit steps.
- The block provides a start/busy/done handshake, and holds the result until the next operation.
- Intended as the area-minimal adder in the arithmetic datapath, where throughput is not critical.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new addition; sampled only when busy=0
- a  input  W  operand A; sampled on the accepting edge
- b  input  W  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  W  result; valid from done, held until the next accepted start or reset
- cout  output  1  final carry-out; same validity as sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry FF=0, bit counter=0.
- States:
  - IDLE: waiting for start.
  - RUN: W bit steps.
  - DONE: one cycle, done=1.
- Arithmetic element: exactly one `full_adder` instance, inputs (a_sh[0], b_sh[0], carry_q). No `+` operator on operands.
- Accept:
  - In IDLE or DONE, start=1 at edge E0 latches a_sh<=a, b_sh<=b, carry_q<=cin, count<=0, and moves the state to RUN.
  - busy=1 from E0.
  - sum and cout are cleared to 0 at E0.
- RUN step at each edge E1..EW:
  - sum shifts right with the FA sum bit entering the MSB.
  - a_sh and b_sh shift right (zero fill).
  - carry_q <= FA carry.
  - count increments.
- Completion:
  - At edge EW (count reaches W-1 before the edge), the state moves to DONE.
  - At that edge: busy<=0, done<=1, and cout<=FA carry of the final bit.
  - Latency is exactly W clocks from the accepting edge to done high.
  - For W=1, done rises at E1.
- DONE:
  - done=1 for exactly one cycle.
  - The next edge goes to IDLE, or to RUN if start=1 (back-to-back accept; done drops).
- start while busy=1 is ignored. It has no effect on operands, count or outputs, and is not queued.
- Operands a, b and cin may change freely while busy. Only values at the accepting edge matter.
- Reset mid-operation (rst=1 in RUN or DONE) aborts at that edge. All outputs return to reset values, and no done pulse is generated.
- rst and start high at the same edge: rst wins.
- Result: sum equals (a+b+cin) mod 2^W; cout equals bit W of a+b+cin. Unsigned semantics.
- Outside DONE and IDLE-after-completion, sum holds intermediate shift contents. Consumers use sum only when busy=0.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - An extra input port `sub` (1 bit), sampled on the accepting edge.
  - When sub=1: b_sh is loaded with ~b and carry_q with 1 (cin ignored), so sum = (a-b) mod 2^W.
  - cout=1 means no borrow (a>=b); cout=0 means borrow.
  - When sub=0: behaviour is identical to the add mode.
- Undefined:
  - No `sub` port.
  - Add only, exactly as above.

Test Plan:
- W=8, a=8'h0F, b=8'h01, cin=0, start pulse at E0 -> busy=1 from E0; done=1 only in the cycle after E8; sum=8'h10, cout=0, held until the next start.
- W=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start accepted, then start=1 held with new operands a=8'h55, b=8'h22 at E3 -> ignored; result is that of the first operands; done pulses once after E8.
- Back-to-back operations: start=1 during the DONE cycle with a=8'h80, b=8'h80 -> accepted; done low next cycle; second done after W more clocks with sum=8'h00, cout=1.
- Reset mid-operation: rst=1 at E4 of a run -> busy=0, done=0, sum=0, cout=0 the next cycle; no done pulse follows; next start completes normally.
- SERIAL_ADD_SUB_EN defined, W=8: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder stepped LSB first over W clocks.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined (adds a sub port).
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          load;
  logic          step;
  logic          last;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry_q;
  logic [CW-1:0] count;
  logic          fa_s;
  logic          fa_c;
  logic          neg;
  logic [W-1:0]  b_ld;
  logic [W-1:0]  sum_n;
  logic [W-1:0]  a_n;
  logic [W-1:0]  b_n;

`ifdef SERIAL_ADD_SUB_EN
  assign neg = sub;
`else
  assign neg = 1'b0;
`endif

  assign b_ld = neg ? ~b : b;
  assign last = (count == CW'(W - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // Shifted views; written this way so W=1 needs no special slice.
  always_comb begin
    sum_n        = sum >> 1;
    sum_n[W-1]   = fa_s;
    a_n          = a_sh >> 1;
    b_n          = b_sh >> 1;
  end

  // Next-state and step/load strobes.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand shifters, carry FF, bit counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (load) begin
      a_sh    <= a;
      b_sh    <= b_ld;
      carry_q <= neg ? 1'b1 : cin;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (step) begin
      a_sh    <= a_n;
      b_sh    <= b_n;
      carry_q <= fa_c;
      count   <= count + CW'(1);
      sum     <= sum_n;
      if (last) cout <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a plain-arithmetic model.
// Directed cases, ignored starts, back-to-back, reset abort, random ops.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_r;

  serial_add_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [W:0] obs,
                       input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y,
    input logic c, input logic s);
    logic [W-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub_i = 1'($urandom);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] ta,
                        input logic [W-1:0] tb,
                        input logic tc,
                        input logic ts,
                        input bit noise);
    exp_r = model(ta, tb, tc, ts);
    a = ta; b = tb; cin = tc; sub_i = ts;
    start = 1'b1;
    tick();
    check("acc_busy", busy, 1);
    check("acc_done", done, 0);
    check("acc_sum", sum, 0);
    check("acc_cout", cout, 0);
    for (int k = 1; k < W; k++) begin
      start = noise;
      scramble();
      tick();
      check("run_busy", busy, 1);
      check("run_done", done, 0);
    end
    start = noise;
    scramble();
    tick();
    start = 1'b0;
    check("done_hi", done, 1);
    check("done_busy", busy, 0);
    check("res_sum", sum, exp_r[W-1:0]);
    check("res_cout", cout, exp_r[W]);
  endtask

  task automatic hold_check();
    start = 1'b0;
    scramble();
    tick();
    check("hold_done", done, 0);
    check("hold_busy", busy, 0);
    check("hold_sum", sum, exp_r[W-1:0]);
    check("hold_cout", cout, exp_r[W]);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    hold_check();
    hold_check();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    hold_check();
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    hold_check();

    run_op(8'h12, 8'h34, 1'b1, 1'b0, 1);
    hold_check();

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
    hold_check();

    a = 8'h3C; b = 8'h5A; cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    seen = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("abort_quiet", {8'h00, seen}, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
    hold_check();

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    hold_check();
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
    hold_check();
`endif

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rc;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`endif
      run_op(ra, rb, rc, rs, bit'($urandom));
      if ($urandom_range(1, 0) == 1) hold_check();
    end
    hold_check();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
